// File: rtl/pipe_hazard_pkg.sv
// rtl/pipe_hazard_pkg.sv - shared types and helpers for the forwarding/hazard scoreboard
package pipe_hazard_pkg;

  // Widest register address the scoreboard entries can hold; narrower REG_AW is zero-extended.
  localparam int RD_W = 8;

  // Register 0 is hard-wired and never produces a hazard or a forward.
  localparam logic [RD_W-1:0] REG_ZERO = '0;

  // One in-flight writer: valid, writes a register, is a load, destination.
  typedef struct packed {
    logic            v;
    logic            we;
    logic            ld;
    logic [RD_W-1:0] rd;
  } inflight_t;

  // Bits needed to encode 0 (regfile) plus stages 1..fwd_stages.
  function automatic int sel_width(input int fwd_stages);
    return (fwd_stages < 1) ? 1 : $clog2(fwd_stages + 1);
  endfunction

endpackage

// File: rtl/hazard_match.sv
// rtl/hazard_match.sv - youngest-writer priority encoder and ready check for one source tag
module hazard_match
  import pipe_hazard_pkg::*;
#(
  parameter int NUM_E    = 3,
  parameter int LO       = 0,
  parameter int HI       = 2,
  parameter int DIST     = 0,
  parameter int LOAD_LAT = 1,
  parameter int IDX_W    = 2
) (
  input  inflight_t        i_e [NUM_E],
  input  logic [RD_W-1:0]  i_tag,
  output logic             o_hit,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_ready
);

  // Scan oldest to youngest so the youngest matching writer is what remains on the outputs;
  // readiness is judged at the stage the entry will occupy DIST cycles from now.
  always_comb begin
    o_hit   = 1'b0;
    o_idx   = '0;
    o_ready = 1'b1;
    for (int j = HI; j >= LO; j--) begin
      if (i_e[j].v && i_e[j].we && (i_e[j].rd == i_tag) && (i_tag != REG_ZERO)) begin
        o_hit   = 1'b1;
        o_idx   = IDX_W'(j);
        o_ready = !i_e[j].ld || ((j + DIST) >= (1 + LOAD_LAT));
      end
    end
  end

endmodule

// File: rtl/pipe_fwd_scoreboard.sv
// rtl/pipe_fwd_scoreboard.sv - forwarding selects and load-use stall; FWD_ID_BRANCH_EN adds ID branch forwarding
module pipe_fwd_scoreboard
  import pipe_hazard_pkg::*;
#(
  parameter int  REG_AW     = 5,
  parameter int  NUM_SRC    = 2,
  parameter int  FWD_STAGES = 2,
  parameter int  LOAD_LAT   = 1,
  localparam int SEL_W      = sel_width(FWD_STAGES)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      hold,
  input  logic                      flush,
  input  logic                      id_valid,
  input  logic                      id_we,
  input  logic                      id_is_load,
  input  logic [REG_AW-1:0]         id_rd,
  input  logic [NUM_SRC*REG_AW-1:0] id_src,
  output logic                      stall,
  output logic [NUM_SRC*SEL_W-1:0]  fwd_sel
`ifdef FWD_ID_BRANCH_EN
  ,
  input  logic                      id_is_branch,
  output logic [NUM_SRC*SEL_W-1:0]  id_fwd_sel
`endif
);

  // r_e[0] is EX, r_e[k] is EX+k.
  inflight_t          r_e   [0:FWD_STAGES];
  logic [RD_W-1:0]    r_tag [NUM_SRC];
  inflight_t          w_id_entry;
  logic               w_issue;
  logic               w_br_stall;
  logic [NUM_SRC-1:0] w_src_block;
`ifdef FWD_ID_BRANCH_EN
  logic [NUM_SRC-1:0] w_br_block;
`endif

  assign w_issue    = id_valid & ~stall & ~flush;
  assign w_id_entry = '{v: 1'b1, we: id_we, ld: id_is_load, rd: RD_W'(id_rd)};

  // Shift the writer pipeline and capture EX source tags; hold freezes all, flush kills EX in place.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int j = 0; j <= FWD_STAGES; j++) r_e[j] <= '0;
      for (int i = 0; i < NUM_SRC; i++) r_tag[i] <= '0;
    end else if (hold) begin
      if (flush) begin
        r_e[0] <= '0;
        for (int i = 0; i < NUM_SRC; i++) r_tag[i] <= '0;
      end
    end else begin
      for (int j = 1; j <= FWD_STAGES; j++) r_e[j] <= r_e[j-1];
      r_e[0] <= w_issue ? w_id_entry : '0;
      for (int i = 0; i < NUM_SRC; i++)
        r_tag[i] <= w_issue ? RD_W'(id_src[i*REG_AW +: REG_AW]) : '0;
    end
  end

  genvar g;
  generate
    for (g = 0; g < NUM_SRC; g++) begin : g_src
      logic [RD_W-1:0]  w_id_tag;
      logic             w_ex_hit;
      logic [SEL_W-1:0] w_ex_idx;
      logic             w_unused_ex_rdy;
      logic             w_id_hit;
      logic             w_id_rdy;
      logic [SEL_W-1:0] w_unused_id_idx;

      assign w_id_tag = RD_W'(id_src[g*REG_AW +: REG_AW]);

      // EX forwarding: youngest writer in stages 1..FWD_STAGES, from registered state only.
      hazard_match #(
        .NUM_E(FWD_STAGES + 1), .LO(1), .HI(FWD_STAGES), .DIST(0),
        .LOAD_LAT(LOAD_LAT), .IDX_W(SEL_W)
      ) u_ex (
        .i_e(r_e), .i_tag(r_tag[g]),
        .o_hit(w_ex_hit), .o_idx(w_ex_idx), .o_ready(w_unused_ex_rdy)
      );
      assign fwd_sel[g*SEL_W +: SEL_W] = (r_e[0].v && w_ex_hit) ? w_ex_idx : '0;

      // ID stall: entries one stage short of where the consumer will look from EX.
      hazard_match #(
        .NUM_E(FWD_STAGES + 1), .LO(0), .HI(FWD_STAGES - 1), .DIST(1),
        .LOAD_LAT(LOAD_LAT), .IDX_W(SEL_W)
      ) u_id (
        .i_e(r_e), .i_tag(w_id_tag),
        .o_hit(w_id_hit), .o_idx(w_unused_id_idx), .o_ready(w_id_rdy)
      );
      assign w_src_block[g] = w_id_hit & ~w_id_rdy;

`ifdef FWD_ID_BRANCH_EN
      logic             w_br_hit;
      logic [SEL_W-1:0] w_br_idx;
      logic             w_br_rdy;

      // ID branch compare: a writer still in EX or an unready load cannot be forwarded yet.
      hazard_match #(
        .NUM_E(FWD_STAGES + 1), .LO(0), .HI(FWD_STAGES), .DIST(0),
        .LOAD_LAT(LOAD_LAT), .IDX_W(SEL_W)
      ) u_br (
        .i_e(r_e), .i_tag(w_id_tag),
        .o_hit(w_br_hit), .o_idx(w_br_idx), .o_ready(w_br_rdy)
      );
      assign w_br_block[g] = w_br_hit & ((w_br_idx == '0) | ~w_br_rdy);
      assign id_fwd_sel[g*SEL_W +: SEL_W] = w_br_hit ? w_br_idx : '0;
`endif
    end
  endgenerate

`ifdef FWD_ID_BRANCH_EN
  assign w_br_stall = id_is_branch & (|w_br_block);
`else
  assign w_br_stall = 1'b0;
`endif

  assign stall = id_valid & ~flush & ((|w_src_block) | w_br_stall);

endmodule
